// File: rtl/inst_dec_pipe.sv
// Handshaked 16-bit instruction decoder with a single registered output stage and a
// per-register scoreboard that stalls issue on RAW/WAW hazards until writeback.
module inst_dec_pipe #(
  parameter int unsigned DATA_W    = 16,
  parameter logic [15:0] NOWB_MASK = 16'h3080,
  parameter logic [15:0] IMM_MASK  = 16'h0300,
  parameter logic [15:0] SEXT_MASK = 16'h0100,
  parameter bit          SB_EN     = 1'b1
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_valid,
  input  logic [15:0]       I_inst,
  output logic              O_ready,
  output logic              O_valid,
  input  logic              I_ready,
  input  logic              I_flush,
  output logic [4:0]        O_aluop,
  output logic [2:0]        O_selA,
  output logic [2:0]        O_selB,
  output logic [2:0]        O_selD,
  output logic [DATA_W-1:0] O_imm,
  output logic              O_regwe,
  input  logic              I_wb_valid,
  input  logic [2:0]        I_wb_sel,
  output logic [7:0]        O_busy
);

  logic [3:0]        in_cls;
  logic [2:0]        in_sel_a, in_sel_b, in_sel_d;
  logic              in_regwe, in_readb, in_sext;
  logic [DATA_W-1:0] in_imm;

  assign in_cls   = I_inst[15:12];
  assign in_sel_a = I_inst[10:8];
  assign in_sel_b = I_inst[7:5];
  assign in_sel_d = I_inst[4:2];
  assign in_regwe = ~NOWB_MASK[in_cls];
  assign in_readb = ~IMM_MASK[in_cls];
  assign in_sext  = SEXT_MASK[in_cls];

  if (DATA_W > 8) begin : g_imm_ext
    assign in_imm = {{(DATA_W-8){in_sext & I_inst[7]}}, I_inst[7:0]};
  end else begin : g_imm_narrow
    assign in_imm = I_inst[7:0];
  end

  logic              valid_q, valid_d;
  logic [4:0]        aluop_q;
  logic [2:0]        sel_a_q, sel_b_q, sel_d_q;
  logic [DATA_W-1:0] imm_q;
  logic              regwe_q;
  logic              hazard, fire_in, fire_out;

  assign O_ready  = (~valid_q | I_ready | I_flush) & ~hazard;
  assign fire_in  = I_valid & O_ready;
  assign fire_out = valid_q & I_ready & ~I_flush;

  always_comb begin
    valid_d = valid_q;
    if (fire_in) begin
      valid_d = 1'b1;
    end else if (fire_out || I_flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      valid_q <= 1'b0;
      aluop_q <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      sel_d_q <= '0;
      imm_q   <= '0;
      regwe_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      // Fields hold their last values once the stage empties.
      if (fire_in) begin
        aluop_q <= I_inst[15:11];
        sel_a_q <= in_sel_a;
        sel_b_q <= in_sel_b;
        sel_d_q <= in_sel_d;
        imm_q   <= in_imm;
        regwe_q <= in_regwe;
      end
    end
  end

  if (SB_EN) begin : g_sb
    logic [7:0] sb_q, sb_d;
    logic       stage_hit;

    // The held writer is not yet in the scoreboard, so compare against it directly.
    assign stage_hit = valid_q & regwe_q & ~I_flush &
                       ((sel_d_q == in_sel_a) |
                        (in_readb & (sel_d_q == in_sel_b)) |
                        (in_regwe & (sel_d_q == in_sel_d)));

    assign hazard = sb_q[in_sel_a] | (in_readb & sb_q[in_sel_b]) |
                    (in_regwe & sb_q[in_sel_d]) | stage_hit;

    always_comb begin
      sb_d = sb_q;
      if (I_wb_valid) begin
        sb_d[I_wb_sel] = 1'b0;
      end
      // Applied after the clear so a same-register set wins.
      if (fire_out && regwe_q) begin
        sb_d[sel_d_q] = 1'b1;
      end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
        sb_q <= '0;
      end else begin
        sb_q <= sb_d;
      end
    end

    assign O_busy = sb_q;
  end else begin : g_no_sb
    assign hazard = 1'b0;
    assign O_busy = '0;
  end

  assign O_valid = valid_q;
  assign O_aluop = aluop_q;
  assign O_selA  = sel_a_q;
  assign O_selB  = sel_b_q;
  assign O_selD  = sel_d_q;
  assign O_imm   = imm_q;
  assign O_regwe = regwe_q;

endmodule

// File: tb/tb_inst_dec_pipe.sv
// Randomised and directed bench for inst_dec_pipe against a register-pending-set model.
module tb_inst_dec_pipe;

  localparam logic [15:0] NowbMask = 16'h3080;
  localparam logic [15:0] ImmMask  = 16'h0300;
  localparam logic [15:0] SextMask = 16'h0100;

  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_valid = 1'b0;
  logic [15:0] I_inst = '0;
  logic        O_ready, O_valid;
  logic        I_ready = 1'b0;
  logic        I_flush = 1'b0;
  logic [4:0]  O_aluop;
  logic [2:0]  O_selA, O_selB, O_selD;
  logic [15:0] O_imm;
  logic        O_regwe;
  logic        I_wb_valid = 1'b0;
  logic [2:0]  I_wb_sel = '0;
  logic [7:0]  O_busy;

  inst_dec_pipe dut (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_valid    (I_valid),
    .I_inst     (I_inst),
    .O_ready    (O_ready),
    .O_valid    (O_valid),
    .I_ready    (I_ready),
    .I_flush    (I_flush),
    .O_aluop    (O_aluop),
    .O_selA     (O_selA),
    .O_selB     (O_selB),
    .O_selD     (O_selD),
    .O_imm      (O_imm),
    .O_regwe    (O_regwe),
    .I_wb_valid (I_wb_valid),
    .I_wb_sel   (I_wb_sel),
    .O_busy     (O_busy)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [4:0]  aluop;
    logic [2:0]  sa, sb, sd;
    logic [15:0] imm;
    logic        regwe;
    logic        reads_b;
  } dec_t;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  // Model state: the held instruction's decoded fields and the set of pending registers.
  logic       m_valid;
  dec_t       m_f;
  logic [7:0] m_busy;
  logic       last_fire;

  function automatic dec_t decode(input logic [15:0] inst);
    dec_t d;
    int   cls = int'(inst) / 4096;
    int   lo  = int'(inst) % 256;
    d.aluop   = 5'(int'(inst) / 2048);
    d.sa      = 3'((int'(inst) / 256) % 8);
    d.sb      = 3'((int'(inst) / 32) % 8);
    d.sd      = 3'((int'(inst) / 4) % 8);
    d.regwe   = ((int'(NowbMask) >> cls) % 2) == 0;
    d.reads_b = ((int'(ImmMask) >> cls) % 2) == 0;
    if (((int'(SextMask) >> cls) % 2) == 1 && lo >= 128) d.imm = 16'(lo + 'hFF00);
    else d.imm = 16'(lo);
    return d;
  endfunction

  function automatic logic model_ready(input logic [15:0] inst, input logic rdy, input logic fl);
    logic [7:0] pend = m_busy;
    dec_t       d = decode(inst);
    logic       blocked;
    if (m_valid && m_f.regwe && !fl) pend[m_f.sd] = 1'b1;
    blocked = pend[d.sa] || (d.reads_b && pend[d.sb]) || (d.regwe && pend[d.sd]);
    return (!m_valid || rdy || fl) && !blocked;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_f = '{aluop: '0, sa: '0, sb: '0, sd: '0, imm: '0, regwe: 1'b0, reads_b: 1'b0};
    m_busy = '0;
  endtask

  task automatic check_outputs();
    check_eq("valid", O_valid, m_valid);
    check_eq("aluop", O_aluop, m_f.aluop);
    check_eq("selA", O_selA, m_f.sa);
    check_eq("selB", O_selB, m_f.sb);
    check_eq("selD", O_selD, m_f.sd);
    check_eq("imm", O_imm, m_f.imm);
    check_eq("regwe", O_regwe, m_f.regwe);
    check_eq("busy", O_busy, m_busy);
  endtask

  task automatic do_reset();
    I_rst_n = 1'b0;
    I_valid = 1'b0; I_inst = '0; I_ready = 1'b0; I_flush = 1'b0;
    I_wb_valid = 1'b0; I_wb_sel = '0;
    #1;
    model_reset();
    check_outputs();
    @(negedge I_clk);
    I_rst_n = 1'b1;
  endtask

  // One cycle: drive at negedge, check O_ready, advance the model at posedge, check outputs.
  task automatic step(input logic v, input logic [15:0] inst, input logic rdy, input logic fl,
                      input logic wbv, input logic [2:0] wbs);
    logic exp_rdy, fin, fout;
    dec_t d;
    I_valid = v; I_inst = inst; I_ready = rdy; I_flush = fl;
    I_wb_valid = wbv; I_wb_sel = wbs;
    #1;
    exp_rdy = model_ready(inst, rdy, fl);
    check_eq("ready", O_ready, exp_rdy);
    fin  = v && exp_rdy;
    fout = m_valid && rdy && !fl;
    d    = decode(inst);
    @(posedge I_clk);
    if (wbv) m_busy[wbs] = 1'b0;
    if (fout && m_f.regwe) m_busy[m_f.sd] = 1'b1;
    if (fin) begin
      m_valid = 1'b1;
      m_f = d;
    end else if (fout || fl) begin
      m_valid = 1'b0;
    end
    last_fire = fin;
    @(negedge I_clk);
    check_outputs();
  endtask

  function automatic logic [2:0] lowest_busy();
    for (int i = 0; i < 8; i++) if (m_busy[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Present inst until accepted, retiring one pending register per cycle meanwhile.
  task automatic issue(input logic [15:0] inst);
    logic done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1'b1, inst, 1'b1, 1'b0, m_busy != 0, lowest_busy());
      done = last_fire;
    end
    check_eq("issue_accepted", done, 1'b1);
  endtask

  initial begin
    logic       rv, rr, rf, rw;
    logic [2:0] rs;
    model_reset();
    last_fire = 1'b0;
    @(negedge I_clk);
    do_reset();

    // Basic stream and field decode of 0x0804.
    issue(16'h0804);
    check_eq("d0804_aluop", O_aluop, 5'd1);
    check_eq("d0804_selA", O_selA, 3'd0);
    check_eq("d0804_selD", O_selD, 3'd1);
    check_eq("d0804_regwe", O_regwe, 1'b1);
    issue(16'h1000);
    check_eq("d1000_aluop", O_aluop, 5'd2);
    issue(16'h2124);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 3'd0);

    // Immediate extension and a non-writing class.
    do_reset();
    issue(16'h80F0);
    check_eq("imm_sext", O_imm, 16'hFFF0);
    issue(16'h90F0);
    check_eq("imm_zext", O_imm, 16'h00F0);
    do_reset();
    issue(16'hC000);
    check_eq("c12_regwe", O_regwe, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 3'd0);
    check_eq("c12_busy", O_busy, 8'h00);

    // RAW stall on r3 until the cycle after writeback.
    do_reset();
    issue(16'h000C);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 3'd0);
    check_eq("r3_busy", O_busy[3], 1'b1);
    step(1'b1, 16'h0300, 1'b1, 1'b0, 1'b0, 3'd0);
    check_eq("raw_stall", last_fire, 1'b0);
    step(1'b1, 16'h0300, 1'b1, 1'b0, 1'b1, 3'd3);
    check_eq("no_wb_bypass", last_fire, 1'b0);
    check_eq("r3_cleared", O_busy[3], 1'b0);
    step(1'b1, 16'h0300, 1'b1, 1'b0, 1'b0, 3'd0);
    check_eq("raw_issue", O_selA, 3'd3);

    // Backpressure holds the stage; release loads the next instruction.
    do_reset();
    issue(16'h0804);
    step(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 3'd0);
    check_eq("bp_hold", O_aluop, 5'd1);
    step(1'b1, 16'h1000, 1'b1, 1'b0, 1'b0, 3'd0);
    check_eq("bp_release", O_aluop, 5'd2);

    // Flush kills the held r2 writer while a new instruction loads.
    do_reset();
    issue(16'h0008);
    step(1'b1, 16'h0300, 1'b0, 1'b1, 1'b0, 3'd0);
    check_eq("flush_load", O_selA, 3'd3);
    check_eq("flush_nobusy", O_busy[2], 1'b0);

    // Set beats clear on the same register, then asynchronous reset mid-stream.
    do_reset();
    issue(16'h0014);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 3'd0);
    issue(16'h0014);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5);
    check_eq("set_wins", O_busy[5], 1'b1);
    issue(16'h0300);
    #2 I_rst_n = 1'b0;
    #1;
    check_eq("arst_valid", O_valid, 1'b0);
    check_eq("arst_busy", O_busy, 8'h00);
    model_reset();
    @(negedge I_clk);
    I_rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rv = ($urandom % 4) != 0;
      rr = ($urandom % 4) != 0;
      rf = ($urandom % 10) == 0;
      rw = ($urandom % 3) == 0;
      rs = 3'($urandom % 8);
      for (int k = 0; k < 8 && m_busy != 0 && !m_busy[rs]; k++) rs = 3'($urandom % 8);
      step(rv, 16'($urandom), rr, rf, rw, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
